// File: rtl/gauss_conv3x3_stream_if.sv
// Valid/busy pixel stream: master drives vld/data, slave answers with busy.
// A transfer happens on a rising edge where vld=1 and busy=0.
interface gauss_conv3x3_stream_if #(
   parameter int unsigned DATA_W = 24
);
   logic              vld;
   logic [DATA_W-1:0] data;
   logic              busy;

   modport master (output vld, output data, input busy);
   modport slave  (input vld, input data, output busy);
endinterface

// File: rtl/gauss_conv3x3_stream.sv
// Streaming 3x3 Gaussian blur (weights 1-2-1 / 2-4-2 / 1-2-1, /16 rounded)
// over a raster pixel stream, with a per-frame bypass mode.
module gauss_conv3x3_stream #(
   parameter int unsigned CH_W  = 8,
   parameter int unsigned NCH   = 3,
   parameter int unsigned IMG_W = 256,
   parameter int unsigned IMG_H = 256
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   gauss_conv3x3_stream_if.slave  i_rgb,
   input  logic                   i_mode,
   gauss_conv3x3_stream_if.master o_rgb,
   output logic                   o_eof
);
   localparam int unsigned DW    = NCH * CH_W;
   localparam int unsigned SUM_W = CH_W + 4;
   localparam int unsigned CW    = $clog2(IMG_W);
   localparam int unsigned RW    = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic             mode_q;
   logic [DW-1:0]    lb1 [IMG_W];
   logic [DW-1:0]    lb2 [IMG_W];
   logic [DW-1:0]    col_a [3];
   logic [DW-1:0]    col_b [3];
   logic [DW-1:0]    col_n [3];
   logic [DW-1:0]    gauss;
   logic [SUM_W-1:0] sum;
   logic             xfer;
   logic             first_px;
   logic             last_px;
   logic             mode_eff;
   logic             produce;

   assign i_rgb.busy = o_rgb.vld & o_rgb.busy;
   assign xfer       = i_rgb.vld & ~i_rgb.busy;
   assign first_px   = (col == '0) && (row == '0);
   assign last_px    = (col == COL_LAST) && (row == ROW_LAST);
   // Pixel (0,0) must already obey the new frame's mode, so use i_mode directly there.
   assign mode_eff   = first_px ? i_mode : mode_q;
   assign produce    = xfer & (mode_eff | ((row >= RW'(2)) && (col >= CW'(2))));

   // Window = col_a (c-2), col_b (c-1), col_n (c); index 0 is row r-2, 2 is row r.
   always_comb begin
      col_n[0] = lb2[col];
      col_n[1] = lb1[col];
      col_n[2] = i_rgb.data;
   end

   always_comb begin
      gauss = '0;
      sum   = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         sum = SUM_W'(8);
         for (int unsigned r = 0; r < 3; r++) begin
            sum = sum
                + (SUM_W'(col_a[r][k*CH_W +: CH_W]) << ((r == 1) ? 1 : 0))
                + (SUM_W'(col_b[r][k*CH_W +: CH_W]) << ((r == 1) ? 2 : 1))
                + (SUM_W'(col_n[r][k*CH_W +: CH_W]) << ((r == 1) ? 1 : 0));
         end
         gauss[k*CH_W +: CH_W] = sum[SUM_W-1:4];
      end
   end

   always_ff @(posedge i_clk) begin
      if (xfer) begin
         lb1[col] <= i_rgb.data;
         lb2[col] <= lb1[col];
         for (int unsigned r = 0; r < 3; r++) begin
            col_a[r] <= col_b[r];
            col_b[r] <= col_n[r];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         col        <= '0;
         row        <= '0;
         mode_q     <= 1'b0;
         o_rgb.vld  <= 1'b0;
         o_rgb.data <= '0;
         o_eof      <= 1'b0;
      end else begin
         if (xfer) begin
            if (first_px)
               mode_q <= i_mode;
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (produce) begin
            o_rgb.vld  <= 1'b1;
            o_rgb.data <= mode_eff ? i_rgb.data : gauss;
            o_eof      <= last_px;
         end else if (o_rgb.vld && !o_rgb.busy) begin
            o_rgb.vld <= 1'b0;
            o_eof     <= 1'b0;
         end
      end
   end
endmodule

// File: doc/gauss_conv3x3_stream.md
GAUSS_CONV3X3_STREAM -- requirements
Module: gauss_conv3x3_stream

Interface
REQ-001 Parameters SHALL be, one per line:
  CH_W, 8, bits per colour channel (>=4)
  NCH, 3, channels per pixel; channel k occupies data bits [k*CH_W +: CH_W]
  IMG_W, 256, pixels per row (>=3)
  IMG_H, 256, rows per frame (>=3)
REQ-002 Ports SHALL be, one per line:
  i_clk  in  1  single clock, all state on rising edge
  i_rst  in  1  asynchronous, active-high reset
  i_rgb_vld  in  1  input pixel valid
  i_rgb_data  in  NCH*CH_W  input pixel, raster order
  i_rgb_busy  out  1  block cannot accept input this cycle
  i_mode  in  1  0 = 3x3 Gaussian, 1 = bypass
  o_rgb_vld  out  1  output pixel valid
  o_rgb_data  out  NCH*CH_W  output pixel
  o_eof  out  1  qualifies last output pixel of a frame
  o_rgb_busy  in  1  downstream cannot accept output
REQ-003 Single clock domain, i_clk; reset i_rst asynchronous, active-high.

Function
REQ-004 Input transfer occurs on a rising edge where i_rgb_vld=1 and i_rgb_busy=0; output transfer where o_rgb_vld=1 and o_rgb_busy=0.
REQ-005 i_rgb_busy SHALL equal o_rgb_vld AND o_rgb_busy, combinationally.
REQ-006 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 SHALL advance once per input transfer; after (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-007 i_mode SHALL be latched only on the transfer of pixel (0,0); changes mid-frame take effect at the next frame.
REQ-008 Two line buffers, depth IMG_W, width NCH*CH_W, SHALL hold rows r-1 and r-2; a 3x3 window register SHALL shift one column per input transfer.
REQ-009 Gaussian mode: input transfer at (r,c) with r>=2 and c>=2 SHALL produce one output, the window over rows r-2..r, cols c-2..c; no output otherwise; (IMG_W-2)*(IMG_H-2) outputs per frame.
REQ-010 Per channel: sum of weights [1 2 1; 2 4 2; 1 2 1] times pixels, width CH_W+4, result = (sum+8)>>4; never exceeds 2^CH_W-1, no saturation logic.
REQ-011 Bypass mode: every input transfer SHALL produce one output equal to i_rgb_data; IMG_W*IMG_H outputs per frame; line buffers still written.
REQ-012 Latency: an output-producing input transfer at edge k SHALL present o_rgb_vld=1 and data after edge k.
REQ-013 o_rgb_vld, o_rgb_data, o_eof SHALL hold stable while o_rgb_vld=1 and o_rgb_busy=1; no input accepted while stalled, so no pixel is lost or duplicated.
REQ-014 Output transfer with no new output pixel SHALL clear o_rgb_vld; simultaneous output transfer and new output pixel SHALL reload the register with o_rgb_vld remaining 1.
REQ-015 o_eof=1 exactly with the output produced by input (IMG_H-1, IMG_W-1), in either mode; 0 otherwise.

Reset
REQ-016 On i_rst=1, immediately: o_rgb_vld=0, o_rgb_data=0, o_eof=0, row/col counters=0, latched mode=0; i_rgb_busy therefore 0.
REQ-017 Line buffer and window contents SHALL NOT be reset; outputs never depend on stale contents by REQ-009.
REQ-018 Reset mid-frame SHALL abandon the partial frame; the next accepted pixel is (0,0).

Verification (IMG_W=IMG_H=4, CH_W=8, NCH=3)
REQ-019 Constant frame, all channels 100, mode 0, no backpressure -> exactly 4 outputs, all channels 100, o_eof on 4th only.
REQ-020 Impulse: channel 0 = 160 at (1,1), all else 0, mode 0 -> outputs for centres (1,1),(1,2),(2,1),(2,2) channel 0 = 40,20,20,10; other channels 0.
REQ-021 Mode 1, pixels 0..15 in channel 0 -> 16 outputs 0..15 in order, each visible one edge after acceptance, o_eof with 15.
REQ-022 Backpressure: o_rgb_busy held 1 for 5 cycles while o_rgb_vld=1 -> data/o_eof stable, i_rgb_busy=1 throughout, no loss or duplication after release.
REQ-023 i_rst pulsed after 7 pixels accepted, then full constant-50 frame -> exactly 4 outputs of 50, o_eof on 4th.
REQ-024 i_mode toggled 0->1 at pixel (2,0) -> that frame Gaussian (4 outputs); next frame bypass (16 outputs).
